// File: rtl/seq_comparator.sv
// Iterative MSB-first magnitude comparator for branch resolution.
// Scans CHUNK bits per cycle, stops at the first differing chunk, returns {EQ, SL, UL} and taken.
module seq_comparator #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       funct3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       cmp_result,
   output logic             taken
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] TOP = IW'(N - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [2:0]         f3_q;
   logic [IW-1:0]      idx;

   int unsigned        base;
   logic [WIDTH-1:0]   a_sh, b_sh;
   logic [CHUNK-1:0]   a_ch, b_ch;
   logic               differ, ult, last, sign_diff;
   logic               eq_n, sl_n, ul_n, taken_n;

   assign in_ready = (state == IDLE);

   always_comb begin
      base      = 32'(idx) * CHUNK;
      a_sh      = a_q >> base;
      b_sh      = b_q >> base;
      a_ch      = a_sh[CHUNK-1:0];
      b_ch      = b_sh[CHUNK-1:0];
      differ    = (a_ch != b_ch);
      ult       = (a_ch < b_ch);
      last      = (idx == '0);
      sign_diff = a_q[WIDTH-1] ^ b_q[WIDTH-1];
      // Only consumed when the scan terminates, so !differ here means every chunk matched.
      eq_n      = ~differ;
      ul_n      = differ & ult;
      sl_n      = differ & (sign_diff ? a_q[WIDTH-1] : ult);
      case (f3_q)
         3'b000:  taken_n = eq_n;
         3'b001:  taken_n = ~eq_n;
         3'b100:  taken_n = sl_n;
         3'b101:  taken_n = ~sl_n;
         3'b110:  taken_n = ul_n;
         3'b111:  taken_n = ~ul_n;
         default: taken_n = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= TOP;
         a_q        <= '0;
         b_q        <= '0;
         f3_q       <= '0;
         out_valid  <= 1'b0;
         cmp_result <= '0;
         taken      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  f3_q  <= funct3;
                  idx   <= TOP;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (differ || last) begin
                  cmp_result <= {eq_n, sl_n, ul_n};
                  taken      <= taken_n;
                  out_valid  <= 1'b1;
                  state      <= DONE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_comparator.sv
// Directed and randomised checks of seq_comparator (WIDTH=32, CHUNK=8) against a golden model,
// with expected results queued at request time and popped when out_valid appears.
module tb_seq_comparator;

   localparam int W = 32;
   localparam int C = 8;
   localparam int N = W / C;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [2:0]    funct3 = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [2:0]    cmp_result;
   logic          taken;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [2:0] cmp;
      logic       tk;
      int         k;
   } exp_t;

   exp_t sbq[$];

   seq_comparator #(.WIDTH(W), .CHUNK(C)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .funct3     (funct3),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .cmp_result (cmp_result),
      .taken      (taken)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                  input logic [2:0] tf);
      exp_t e;
      logic eq, sl, ul, found;
      logic [C-1:0] ca, cb;
      e.k   = N;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         ca = ta[i*C +: C];
         cb = tb_[i*C +: C];
         if (!found && ca != cb) begin
            e.k   = N - i;
            found = 1'b1;
         end
      end
      eq = (ta == tb_);
      ul = (ta < tb_);
      sl = ($signed(ta) < $signed(tb_));
      e.cmp = {eq, sl, ul};
      case (tf)
         3'b000:  e.tk = eq;
         3'b001:  e.tk = ~eq;
         3'b100:  e.tk = sl;
         3'b101:  e.tk = ~sl;
         3'b110:  e.tk = ul;
         3'b111:  e.tk = ~ul;
         default: e.tk = 1'b0;
      endcase
      return e;
   endfunction

   // One full request/response; hold > 0 stalls out_ready for that many cycles after out_valid.
   task automatic run_req(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [2:0] tf,
                          input bit perturb, input int hold);
      exp_t got;
      int   k;
      a         = ta;
      b         = tb_;
      funct3    = tf;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      check("in_ready_idle", in_ready, 1);
      @(posedge clk); #1;
      sbq.push_back(model(ta, tb_, tf));
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < N + 2) begin
         if (perturb) begin
            a      = $urandom;
            b      = $urandom;
            funct3 = 3'($urandom_range(0, 7));
         end
         @(posedge clk); #1;
         k++;
      end
      got = sbq.pop_front();
      check("out_valid_timeout", out_valid, 1);
      if (!out_valid) return;
      check("latency", k, got.k);
      check("cmp_result", cmp_result, got.cmp);
      check("taken", taken, got.tk);
      check("in_ready_done", in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a        = ~ta;
         b        = ta;
         funct3   = ~tf;
         @(posedge clk); #1;
         check("bp_out_valid", out_valid, 1);
         check("bp_cmp_stable", cmp_result, got.cmp);
         check("bp_taken_stable", taken, got.tk);
         check("bp_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("post_out_valid", out_valid, 0);
      check("post_in_ready", in_ready, 1);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      int           mode;

      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_out_valid", out_valid, 0);
      check("rst_cmp", cmp_result, 0);
      check("rst_taken", taken, 0);
      check("rst_in_ready", in_ready, 1);

      run_req(32'h0000_0005, 32'h0000_0005, 3'b000, 0, 0);
      run_req(32'h0000_0005, 32'h0000_0005, 3'b001, 0, 0);
      run_req(32'h8000_0000, 32'h0000_0001, 3'b100, 0, 0);
      run_req(32'h8000_0000, 32'h0000_0001, 3'b111, 0, 0);
      run_req(32'h0000_0100, 32'h0000_0200, 3'b110, 0, 0);
      run_req(32'h0000_0200, 32'h0000_0100, 3'b110, 0, 0);
      run_req(32'h1234_5678, 32'h1234_0000, 3'b101, 0, 5);
      run_req(32'hFFFF_FFFF, 32'h0000_0000, 3'b010, 0, 0);

      // Reset one edge after acceptance: result must be dropped silently.
      a        = 32'h0000_0001;
      b        = 32'h0000_0002;
      funct3   = 3'b110;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      check("busy_in_ready", in_ready, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_cmp", cmp_result, 0);
      check("midrst_taken", taken, 0);
      check("midrst_in_ready", in_ready, 1);
      for (int i = 0; i < N + 2; i++) begin
         @(posedge clk); #1;
         check("midrst_no_pulse", out_valid, 0);
      end
      run_req(32'h0000_0001, 32'h0000_0002, 3'b110, 0, 0);

      for (int i = 0; i < 40; i++) begin
         ra   = $urandom;
         mode = $urandom_range(0, 3);
         case (mode)
            0:       rb = $urandom;
            1:       rb = ra;
            2:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
            default: rb = {ra[31:16], 16'($urandom)};
         endcase
         run_req(ra, rb, 3'($urandom_range(0, 7)), (i % 2) == 1, (i % 7 == 3) ? 2 : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
